// File: rtl/mem_contention_pkg.sv
// Shared types and constants for the tile-to-DRAM contention arbiter.
// The token level register is exposed to software at CSR_TOKEN_LEVEL.
package mem_contention_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   localparam int         TOKEN_W_DEF     = 16;
   localparam logic [7:0] CSR_TOKEN_LEVEL = 8'hD8;

   // A single tile still needs a 1-bit id field.
   function automatic int tid_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_token_bucket.sv
// Token bucket: periodic refill, debit per grant, clamp to ceiling; one-cycle update latency.
// No backpressure; the caller only debits when tokens >= debit, so the sum never goes negative.
module mem_token_bucket #(
   parameter int                 TOKEN_W    = 16,
   parameter logic [TOKEN_W-1:0] TOKEN_INIT = '1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               debit_valid,
   input  logic [TOKEN_W-1:0] debit_len,
   input  logic [TOKEN_W-1:0] cfg_refill,
   input  logic [15:0]        cfg_period,
   input  logic [TOKEN_W-1:0] cfg_token_max,
   output logic [TOKEN_W-1:0] token_level
);

   logic [15:0]        refill_cnt;
   logic               refill_evt;
   logic [TOKEN_W+1:0] token_sum;
   logic [TOKEN_W-1:0] token_d;

   // >= rather than == so a period shortened on the fly cannot strand the counter.
   assign refill_evt = (cfg_period == 16'd0) || (refill_cnt >= cfg_period - 16'd1);

   always_comb begin
      token_sum = {2'b00, token_level};
      if (debit_valid) token_sum = token_sum - {2'b00, debit_len};
      if (refill_evt)  token_sum = token_sum + {2'b00, cfg_refill};
      token_d = (token_sum > {2'b00, cfg_token_max}) ? cfg_token_max : token_sum[TOKEN_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refill_cnt  <= '0;
         token_level <= TOKEN_INIT;
      end else begin
         refill_cnt  <= refill_evt ? 16'd0 : refill_cnt + 16'd1;
         token_level <= token_d;
      end
   end

endmodule

// File: rtl/mem_contention_arbiter.sv
// Round-robin arbiter of NUM_TILES tile requests onto one DRAM port, rate-limited by a token bucket.
// Latency: req_ready at cycle N -> mem_valid at N+1; request held in ISSUE until mem_ready (max 1 grant / 2 cycles).
module mem_contention_arbiter
   import mem_contention_pkg::*;
#(
   parameter int                 NUM_TILES  = 4,
   parameter int                 ADDR_W     = 32,
   parameter int                 LEN_W      = 8,
   parameter int                 TOKEN_W    = TOKEN_W_DEF,
   parameter logic [TOKEN_W-1:0] TOKEN_INIT = 16'hFFFF,
   localparam int                TID_W      = tid_w(NUM_TILES)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_TILES-1:0]        req_valid,
   output logic [NUM_TILES-1:0]        req_ready,
   input  logic [NUM_TILES*ADDR_W-1:0] req_addr,
   input  logic [NUM_TILES*LEN_W-1:0]  req_len,
   output logic                        mem_valid,
   input  logic                        mem_ready,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [LEN_W-1:0]            mem_len,
   output logic [TID_W-1:0]            mem_tile_id,
   input  logic                        cfg_enable,
   input  logic [TOKEN_W-1:0]          cfg_refill,
   input  logic [15:0]                 cfg_period,
   input  logic [TOKEN_W-1:0]          cfg_token_max,
   output logic [TOKEN_W-1:0]          token_level,
   output logic [31:0]                 stall_cycles
);

   state_t               state_q, state_d;
   logic [TID_W-1:0]     rr_ptr;
   logic [LEN_W-1:0]     eff_len [NUM_TILES];
   logic [NUM_TILES-1:0] elig;
   logic                 win_found;
   logic [TID_W-1:0]     win_idx;
   logic                 grant;
   logic                 stall_evt;

   // Zero-length bursts are treated as one beat both for the grant and the debit.
   always_comb begin
      for (int i = 0; i < NUM_TILES; i++) begin
         eff_len[i] = (req_len[i*LEN_W +: LEN_W] == '0) ? LEN_W'(1) : req_len[i*LEN_W +: LEN_W];
         elig[i]    = req_valid[i] && (!cfg_enable || (32'(token_level) >= 32'(eff_len[i])));
      end
   end

   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NUM_TILES; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_TILES) idx = idx - NUM_TILES;
         if (!win_found && elig[idx]) begin
            win_found = 1'b1;
            win_idx   = TID_W'(idx);
         end
      end
   end

   // rst_n gate keeps req_ready low while reset is held, even though the FSM idles.
   assign grant     = rst_n && (state_q == IDLE) && win_found;
   assign stall_evt = (state_q == IDLE) && cfg_enable && (|req_valid) && !win_found;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      mem_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant) begin
               req_ready = NUM_TILES'(1) << win_idx;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            mem_valid = 1'b1;
            if (mem_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr      <= '0;
         mem_addr    <= '0;
         mem_len     <= '0;
         mem_tile_id <= '0;
      end else if (grant) begin
         mem_addr    <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
         mem_len     <= eff_len[win_idx];
         mem_tile_id <= win_idx;
         rr_ptr      <= (int'(win_idx) == NUM_TILES - 1) ? '0 : win_idx + TID_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               stall_cycles <= '0;
      else if (stall_evt && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
   end

   mem_token_bucket #(
      .TOKEN_W    (TOKEN_W),
      .TOKEN_INIT (TOKEN_INIT)
   ) u_token_bucket (
      .clk           (clk),
      .rst_n         (rst_n),
      .debit_valid   (grant && cfg_enable),
      .debit_len     (TOKEN_W'(eff_len[win_idx])),
      .cfg_refill    (cfg_refill),
      .cfg_period    (cfg_period),
      .cfg_token_max (cfg_token_max),
      .token_level   (token_level)
   );

endmodule

// File: tb/tb_mem_contention_arbiter.sv
// Directed bench for mem_contention_arbiter: reset, fairness, token starvation, backpressure,
// refill+debit collision, zero-length bursts and asynchronous reset during ISSUE.
module tb_mem_contention_arbiter;

   localparam int NT = 4;
   localparam int AW = 32;
   localparam int LW = 8;
   localparam int TW = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NT-1:0]     req_valid;
   logic [NT-1:0]     req_ready;
   logic [NT*AW-1:0]  req_addr;
   logic [NT*LW-1:0]  req_len;
   logic              mem_valid;
   logic              mem_ready;
   logic [AW-1:0]     mem_addr;
   logic [LW-1:0]     mem_len;
   logic [1:0]        mem_tile_id;
   logic              cfg_enable;
   logic [TW-1:0]     cfg_refill;
   logic [15:0]       cfg_period;
   logic [TW-1:0]     cfg_token_max;
   logic [TW-1:0]     token_level;
   logic [31:0]       stall_cycles;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_contention_arbiter #(
      .NUM_TILES (NT),
      .ADDR_W    (AW),
      .LEN_W     (LW),
      .TOKEN_W   (TW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_len       (req_len),
      .mem_valid     (mem_valid),
      .mem_ready     (mem_ready),
      .mem_addr      (mem_addr),
      .mem_len       (mem_len),
      .mem_tile_id   (mem_tile_id),
      .cfg_enable    (cfg_enable),
      .cfg_refill    (cfg_refill),
      .cfg_period    (cfg_period),
      .cfg_token_max (cfg_token_max),
      .token_level   (token_level),
      .stall_cycles  (stall_cycles)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_tile(input int i, input logic v, input logic [AW-1:0] a, input logic [LW-1:0] l);
      req_valid[i]         = v;
      req_addr[i*AW +: AW] = a;
      req_len[i*LW +: LW]  = l;
   endtask

   int tile_cnt [NT];
   int grants;
   int hs [$];
   int exp_hs [5];

   initial begin
      req_valid     = '0;
      req_addr      = '0;
      req_len       = '0;
      mem_ready     = 1'b0;
      cfg_enable    = 1'b0;
      cfg_refill    = '0;
      cfg_period    = '0;
      cfg_token_max = 16'hFFFF;

      // Reset state with every tile requesting
      rst_n     = 1'b0;
      req_valid = 4'hF;
      repeat (3) @(negedge clk);
      check("rst_token", token_level, 16'hFFFF);
      check("rst_mem_valid", mem_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_stall", stall_cycles, 0);
      check("rst_mem_regs", {mem_addr, mem_len, mem_tile_id}, 0);

      // Fairness, rate limit off
      for (int i = 0; i < NT; i++) begin
         set_tile(i, 1'b1, 32'h1000 * (i + 1), 8'd4);
         tile_cnt[i] = 0;
      end
      mem_ready = 1'b1;
      @(negedge clk);
      rst_n  = 1'b1;
      grants = 0;
      for (int c = 0; c < 300 && grants < 100; c++) begin
         @(negedge clk);
         if (mem_valid && mem_ready) begin
            check("rr_tile", mem_tile_id, grants % 4);
            check("rr_addr_len", {mem_addr, mem_len}, {32'h1000 * (grants % 4 + 1), 8'd4});
            tile_cnt[mem_tile_id]++;
            grants++;
         end
      end
      req_valid = '0;
      check("rr_grants", grants, 100);
      for (int i = 0; i < NT; i++) check("rr_per_tile", tile_cnt[i], 25);
      check("rr_token", token_level, 16'hFFFF);
      check("rr_stall", stall_cycles, 0);

      // Token starvation: max 16, +4 every 10 cycles, tile0 bursts of 8
      rst_n         = 1'b0;
      cfg_enable    = 1'b1;
      cfg_token_max = 16'd16;
      cfg_refill    = 16'd4;
      cfg_period    = 16'd10;
      set_tile(0, 1'b0, 32'h2000, 8'd8);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("tb_start_token", token_level, 16);
      req_valid[0] = 1'b1;
      for (int c = 2; c <= 61; c++) begin
         @(negedge clk);
         if (c == 5)  check("tb_empty", token_level, 0);
         if (c == 20) check("tb_token20", token_level, 8);
         if (c == 20) check("tb_stall20", stall_cycles, 15);
         if (c == 40) check("tb_stall40", stall_cycles, 33);
         if (c == 60) check("tb_stall60", stall_cycles, 51);
         if (mem_valid && mem_ready) hs.push_back(c);
      end
      req_valid = '0;
      exp_hs = '{2, 4, 21, 41, 61};
      check("tb_hs_count", hs.size(), 5);
      for (int i = 0; i < 5; i++)
         check("tb_hs_cycle", (i < hs.size()) ? hs[i] : -1, exp_hs[i]);

      // Refill and debit in the same cycle, then a zero-length burst
      rst_n      = 1'b0;
      cfg_period = 16'd4;
      set_tile(0, 1'b0, 32'h3000, 8'd8);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rd_start_token", token_level, 16);
      req_valid[0] = 1'b1;
      @(negedge clk);
      check("rd_issue1", mem_valid, 1);
      @(negedge clk);
      check("rd_token8", token_level, 8);
      check("rd_ready2", req_ready, 4'b0001);
      @(negedge clk);
      check("rd_collide", token_level, 4);
      set_tile(0, 1'b1, 32'h3004, 8'd0);
      @(negedge clk);
      check("len0_ready", req_ready, 4'b0001);
      @(negedge clk);
      check("len0_mem", {mem_valid, mem_addr, mem_len}, {1'b1, 32'h3004, 8'd1});
      check("len0_token", token_level, 3);
      req_valid = '0;

      // Backpressure: request held for 50 cycles of mem_ready=0
      rst_n         = 1'b0;
      cfg_enable    = 1'b0;
      cfg_token_max = 16'hFFFF;
      cfg_refill    = '0;
      cfg_period    = '0;
      mem_ready     = 1'b0;
      set_tile(2, 1'b0, 32'hABCD, 8'd5);
      @(negedge clk);
      rst_n        = 1'b1;
      req_valid[2] = 1'b1;
      #1;
      check("bp_grant", req_ready, 4'b0100);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         check("bp_hold", {mem_valid, req_ready, mem_addr, mem_len, mem_tile_id},
               {1'b1, 4'b0000, 32'hABCD, 8'd5, 2'd2});
         if (k == 0) set_tile(2, 1'b0, 32'hDEAD, 8'd9);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      check("bp_done", mem_valid, 0);

      // Asynchronous reset while in ISSUE, then pointer restart
      mem_ready = 1'b0;
      set_tile(1, 1'b1, 32'h1111, 8'd2);
      set_tile(3, 1'b1, 32'h3333, 8'd2);
      @(negedge clk);
      check("ar_issue", {mem_valid, mem_tile_id, mem_addr}, {1'b1, 2'd3, 32'h3333});
      #2 rst_n = 1'b0;
      #1;
      check("ar_drop", {mem_valid, req_ready}, 0);
      set_tile(0, 1'b1, 32'h0F00, 8'd3);
      set_tile(2, 1'b1, 32'h2222, 8'd3);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ar_first_ready", req_ready, 4'b0001);
      @(negedge clk);
      check("ar_first_issue", {mem_valid, mem_tile_id, mem_addr}, {1'b1, 2'd0, 32'h0F00});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
